// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM stage: exception codes, stage FSM encoding
// and the ALU op encodings used by the EX stage.
package ex_mem_stage_pkg;

   localparam int unsigned CAUSE_W  = 5;

   localparam int unsigned EXC_OV   = 12;
   localparam int unsigned EXC_ADEL = 4;
   localparam int unsigned EXC_ADES = 5;

   typedef enum logic {
      RUN      = 1'b0,
      EXC_WAIT = 1'b1
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_ADDU = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_SUBU = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_SLL  = 4'd10,
      ALU_SRL  = 4'd11,
      ALU_SRA  = 4'd12,
      ALU_LUI  = 4'd13
   } alu_op_e;

   function automatic logic misaligned_word(input logic [1:0] addr_lo);
      return addr_lo != 2'b00;
   endfunction

endpackage

// File: rtl/ex_mem_stage_exc_detect.sv
// Combinational fault classifier for the EX/MEM stage: overflow takes
// priority over load address error, which takes priority over store address error.
module ex_mem_stage_exc_detect
   import ex_mem_stage_pkg::*;
#(
   parameter int unsigned OV_CODE   = 12,
   parameter int unsigned ADEL_CODE = 4,
   parameter int unsigned ADES_CODE = 5
) (
   input  logic               alu_exception,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [1:0]         addr_lo,
   output logic               fault,
   output logic [CAUSE_W-1:0] cause
);

   always_comb begin
      fault = 1'b0;
      cause = '0;
      if (alu_exception) begin
         fault = 1'b1;
         cause = CAUSE_W'(OV_CODE);
      end else if (mem_read && misaligned_word(addr_lo)) begin
         fault = 1'b1;
         cause = CAUSE_W'(ADEL_CODE);
      end else if (mem_write && misaligned_word(addr_lo)) begin
         fault = 1'b1;
         cause = CAUSE_W'(ADES_CODE);
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with overflow / misaligned-access exception capture.
// Optional forwarding outputs are enabled by defining EX_MEM_FWD_EN.
module ex_mem_stage #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned EXC_OV     = ex_mem_stage_pkg::EXC_OV,
   parameter int unsigned EXC_ADEL   = ex_mem_stage_pkg::EXC_ADEL,
   parameter int unsigned EXC_ADES   = ex_mem_stage_pkg::EXC_ADES
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_W-1:0]     i_alu_result,
   input  logic                  i_alu_exception,
   input  logic [DATA_W-1:0]     i_store_data,
   input  logic [REG_ADDR_W-1:0] i_dest_reg,
   input  logic                  i_reg_write,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic [DATA_W-1:0]     i_pc,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic                  i_exc_ack,
   output logic                  o_valid,
   output logic [DATA_W-1:0]     o_alu_result,
   output logic [DATA_W-1:0]     o_store_data,
   output logic [REG_ADDR_W-1:0] o_dest_reg,
   output logic                  o_reg_write,
   output logic                  o_mem_read,
   output logic                  o_mem_write,
   output logic                  o_exc_req,
   output logic [DATA_W-1:0]     o_epc,
   output logic [4:0]            o_cause,
   output logic                  o_fwd_valid,
   output logic [REG_ADDR_W-1:0] o_fwd_reg,
   output logic [DATA_W-1:0]     o_fwd_data
);

   import ex_mem_stage_pkg::*;

   state_e       state_q;
   state_e       state_d;
   logic         fault;
   logic [4:0]   fault_cause;

   ex_mem_stage_exc_detect #(
      .OV_CODE   (EXC_OV),
      .ADEL_CODE (EXC_ADEL),
      .ADES_CODE (EXC_ADES)
   ) u_exc_detect (
      .alu_exception (i_alu_exception),
      .mem_read      (i_mem_read),
      .mem_write     (i_mem_write),
      .addr_lo       (i_alu_result[1:0]),
      .fault         (fault),
      .cause         (fault_cause)
   );

   // A flush in the same cycle as a faulting accept suppresses the exception.
   always_comb begin
      state_d = state_q;
      o_ready = 1'b1;
      case (state_q)
         RUN: begin
            o_ready = !i_stall;
            if (i_valid && !i_stall && fault && !i_flush)
               state_d = EXC_WAIT;
         end
         EXC_WAIT: begin
            if (i_exc_ack)
               state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= RUN;
         o_valid      <= 1'b0;
         o_alu_result <= '0;
         o_store_data <= '0;
         o_dest_reg   <= '0;
         o_reg_write  <= 1'b0;
         o_mem_read   <= 1'b0;
         o_mem_write  <= 1'b0;
         o_epc        <= '0;
         o_cause      <= '0;
      end else begin
         state_q <= state_d;
         if (i_flush || state_q == EXC_WAIT) begin
            // Anything arriving while an exception is pending is discarded.
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
         end else if (!i_stall) begin
            if (i_valid) begin
               o_valid      <= 1'b1;
               o_alu_result <= i_alu_result;
               o_store_data <= i_store_data;
               o_dest_reg   <= i_dest_reg;
               if (fault) begin
                  o_reg_write <= 1'b0;
                  o_mem_read  <= 1'b0;
                  o_mem_write <= 1'b0;
                  o_epc       <= i_pc;
                  o_cause     <= fault_cause;
               end else begin
                  o_reg_write <= i_reg_write;
                  o_mem_read  <= i_mem_read;
                  o_mem_write <= i_mem_write;
               end
            end else begin
               o_valid     <= 1'b0;
               o_reg_write <= 1'b0;
               o_mem_read  <= 1'b0;
               o_mem_write <= 1'b0;
            end
         end
      end
   end

   assign o_exc_req = (state_q == EXC_WAIT);

`ifdef EX_MEM_FWD_EN
   assign o_fwd_valid = o_valid && o_reg_write && !o_mem_read && (o_dest_reg != '0);
   assign o_fwd_reg   = o_dest_reg;
   assign o_fwd_data  = o_alu_result;
`else
   assign o_fwd_valid = 1'b0;
   assign o_fwd_reg   = '0;
   assign o_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; forwarding checks follow EX_MEM_FWD_EN.
module tb_ex_mem_stage;

   logic        i_clk = 1'b0;
   logic        i_rst, i_valid, i_alu_exception, i_reg_write, i_mem_read, i_mem_write;
   logic        i_stall, i_flush, i_exc_ack;
   logic [31:0] i_alu_result, i_store_data, i_pc;
   logic [4:0]  i_dest_reg;
   logic        o_ready, o_valid, o_reg_write, o_mem_read, o_mem_write, o_exc_req, o_fwd_valid;
   logic [31:0] o_alu_result, o_store_data, o_epc, o_fwd_data;
   logic [4:0]  o_dest_reg, o_cause, o_fwd_reg;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 i_clk = ~i_clk;

   ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_alu_result(i_alu_result), .i_alu_exception(i_alu_exception),
      .i_store_data(i_store_data), .i_dest_reg(i_dest_reg),
      .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_pc(i_pc), .i_stall(i_stall), .i_flush(i_flush), .i_exc_ack(i_exc_ack),
      .o_valid(o_valid), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
      .o_dest_reg(o_dest_reg), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
      .o_mem_write(o_mem_write), .o_exc_req(o_exc_req), .o_epc(o_epc), .o_cause(o_cause),
      .o_fwd_valid(o_fwd_valid), .o_fwd_reg(o_fwd_reg), .o_fwd_data(o_fwd_data)
   );

   task automatic idle();
      i_valid = 0; i_alu_exception = 0; i_reg_write = 0; i_mem_read = 0; i_mem_write = 0;
      i_stall = 0; i_flush = 0; i_exc_ack = 0;
      i_alu_result = '0; i_store_data = '0; i_pc = '0; i_dest_reg = '0;
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic instr(input logic [31:0] res, input logic [4:0] dst, input logic rw,
                        input logic mr, input logic mw, input logic ov, input logic [31:0] pc);
      i_valid = 1; i_alu_result = res; i_dest_reg = dst; i_reg_write = rw;
      i_mem_read = mr; i_mem_write = mw; i_alu_exception = ov; i_pc = pc;
   endtask

   task automatic test_reset();
      idle();
      i_rst = 1;
      cyc(); cyc();
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", o_valid); else pass_cnt++;
      total_cnt++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %0h exp 1", o_ready); else pass_cnt++;
      total_cnt++; if (o_exc_req !== 1'b0) $display("FAIL reset_exc_req got %0h exp 0", o_exc_req); else pass_cnt++;
      total_cnt++; if (o_epc !== 32'h0 || o_cause !== 5'd0) $display("FAIL reset_epc_cause got %h/%0d exp 0/0", o_epc, o_cause); else pass_cnt++;
      total_cnt++; if (o_alu_result !== 32'h0 || o_reg_write !== 1'b0) $display("FAIL reset_data got %h/%0h exp 0/0", o_alu_result, o_reg_write); else pass_cnt++;
      i_rst = 0;
   endtask

   task automatic test_basic();
      instr(32'h10, 5'd8, 1, 0, 0, 0, 32'h0040_0000);
      i_store_data = 32'hdead_beef;
      cyc();
      idle();
      total_cnt++; if (o_valid !== 1'b1) $display("FAIL basic_valid got %0h exp 1", o_valid); else pass_cnt++;
      total_cnt++; if (o_alu_result !== 32'h10) $display("FAIL basic_result got %h exp 00000010", o_alu_result); else pass_cnt++;
      total_cnt++; if (o_dest_reg !== 5'd8 || o_reg_write !== 1'b1) $display("FAIL basic_dest got %0d/%0h exp 8/1", o_dest_reg, o_reg_write); else pass_cnt++;
      total_cnt++; if (o_store_data !== 32'hdead_beef) $display("FAIL basic_store_data got %h exp deadbeef", o_store_data); else pass_cnt++;
      total_cnt++; if (o_exc_req !== 1'b0) $display("FAIL basic_exc_req got %0h exp 0", o_exc_req); else pass_cnt++;
      cyc();
      total_cnt++; if (o_valid !== 1'b0 || o_reg_write !== 1'b0) $display("FAIL bubble got %0h/%0h exp 0/0", o_valid, o_reg_write); else pass_cnt++;
   endtask

   task automatic test_overflow();
      instr(32'h7fff_ffff, 5'd3, 1, 0, 0, 1, 32'h0040_0020);
      cyc();
      instr(32'h44, 5'd4, 1, 0, 0, 0, 32'h0040_0024);
      total_cnt++; if (o_valid !== 1'b1 || o_reg_write !== 1'b0) $display("FAIL ov_gated got %0h/%0h exp 1/0", o_valid, o_reg_write); else pass_cnt++;
      total_cnt++; if (o_exc_req !== 1'b1) $display("FAIL ov_exc_req got %0h exp 1", o_exc_req); else pass_cnt++;
      total_cnt++; if (o_epc !== 32'h0040_0020) $display("FAIL ov_epc got %h exp 00400020", o_epc); else pass_cnt++;
      total_cnt++; if (o_cause !== 5'd12) $display("FAIL ov_cause got %0d exp 12", o_cause); else pass_cnt++;
      #1;
      total_cnt++; if (o_ready !== 1'b1) $display("FAIL ov_ready got %0h exp 1", o_ready); else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         cyc();
         total_cnt++; if (o_valid !== 1'b0 || o_exc_req !== 1'b1) $display("FAIL ov_discard got %0h/%0h exp 0/1", o_valid, o_exc_req); else pass_cnt++;
      end
      // ack together with a new faulting instruction: ack wins, instruction dropped
      instr(32'h1, 5'd4, 1, 0, 0, 1, 32'h0040_0028);
      i_exc_ack = 1;
      cyc();
      idle();
      total_cnt++; if (o_exc_req !== 1'b0 || o_valid !== 1'b0) $display("FAIL ov_ack got %0h/%0h exp 0/0", o_exc_req, o_valid); else pass_cnt++;
      total_cnt++; if (o_epc !== 32'h0040_0020 || o_cause !== 5'd12) $display("FAIL ov_epc_hold got %h/%0d exp 00400020/12", o_epc, o_cause); else pass_cnt++;
      instr(32'h100, 5'd5, 1, 0, 0, 0, 32'h0040_002c);
      i_exc_ack = 1;
      cyc();
      idle();
      total_cnt++; if (o_valid !== 1'b1 || o_alu_result !== 32'h100 || o_exc_req !== 1'b0) $display("FAIL ov_run_again got %0h/%h/%0h exp 1/00000100/0", o_valid, o_alu_result, o_exc_req); else pass_cnt++;
   endtask

   task automatic test_misaligned();
      instr(32'h1002, 5'd2, 1, 1, 0, 0, 32'h100);
      cyc();
      idle();
      total_cnt++; if (o_cause !== 5'd4 || o_mem_read !== 1'b0 || o_reg_write !== 1'b0) $display("FAIL adel got %0d/%0h/%0h exp 4/0/0", o_cause, o_mem_read, o_reg_write); else pass_cnt++;
      total_cnt++; if (o_exc_req !== 1'b1 || o_epc !== 32'h100) $display("FAIL adel_epc got %0h/%h exp 1/00000100", o_exc_req, o_epc); else pass_cnt++;
      i_exc_ack = 1; cyc(); idle();
      instr(32'h1001, 5'd0, 0, 0, 1, 0, 32'h104);
      cyc();
      idle();
      total_cnt++; if (o_cause !== 5'd5 || o_mem_write !== 1'b0 || o_epc !== 32'h104) $display("FAIL ades got %0d/%0h/%h exp 5/0/00000104", o_cause, o_mem_write, o_epc); else pass_cnt++;
      i_exc_ack = 1; cyc(); idle();
      instr(32'h1003, 5'd2, 1, 1, 0, 1, 32'h108);
      cyc();
      idle();
      total_cnt++; if (o_cause !== 5'd12 || o_epc !== 32'h108) $display("FAIL ov_over_adel got %0d/%h exp 12/00000108", o_cause, o_epc); else pass_cnt++;
      i_exc_ack = 1; cyc(); idle();
      instr(32'h1004, 5'd2, 1, 1, 0, 0, 32'h10c);
      cyc();
      idle();
      total_cnt++; if (o_valid !== 1'b1 || o_mem_read !== 1'b1 || o_exc_req !== 1'b0 || o_cause !== 5'd12) $display("FAIL aligned_load got %0h/%0h/%0h/%0d exp 1/1/0/12", o_valid, o_mem_read, o_exc_req, o_cause); else pass_cnt++;
      cyc();
   endtask

   task automatic test_stall();
      instr(32'h200, 5'd6, 1, 0, 0, 0, 32'h200);
      cyc();
      instr(32'h300, 5'd7, 1, 0, 0, 0, 32'h204);
      i_stall = 1;
      #1;
      total_cnt++; if (o_ready !== 1'b0) $display("FAIL stall_ready got %0h exp 0", o_ready); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total_cnt++; if (o_valid !== 1'b1 || o_alu_result !== 32'h200 || o_dest_reg !== 5'd6 || o_ready !== 1'b0) $display("FAIL stall_hold got %0h/%h/%0d/%0h exp 1/00000200/6/0", o_valid, o_alu_result, o_dest_reg, o_ready); else pass_cnt++;
      end
      i_stall = 0;
      cyc();
      idle();
      total_cnt++; if (o_valid !== 1'b1 || o_alu_result !== 32'h300 || o_dest_reg !== 5'd7) $display("FAIL stall_release got %0h/%h/%0d exp 1/00000300/7", o_valid, o_alu_result, o_dest_reg); else pass_cnt++;
      cyc();
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL stall_once got %0h exp 0", o_valid); else pass_cnt++;
   endtask

   task automatic test_flush();
      instr(32'h500, 5'd1, 1, 0, 0, 1, 32'h500);
      i_flush = 1;
      cyc();
      idle();
      total_cnt++; if (o_valid !== 1'b0 || o_exc_req !== 1'b0) $display("FAIL flush_fault got %0h/%0h exp 0/0", o_valid, o_exc_req); else pass_cnt++;
      total_cnt++; if (o_epc !== 32'h108 || o_cause !== 5'd12) $display("FAIL flush_epc got %h/%0d exp 00000108/12", o_epc, o_cause); else pass_cnt++;
      instr(32'h600, 5'd9, 1, 0, 0, 0, 32'h600);
      cyc();
      idle();
      i_stall = 1; i_flush = 1;
      cyc();
      idle();
      total_cnt++; if (o_valid !== 1'b0 || o_reg_write !== 1'b0) $display("FAIL flush_stall got %0h/%0h exp 0/0", o_valid, o_reg_write); else pass_cnt++;
      instr(32'h0, 5'd1, 1, 0, 0, 1, 32'h700);
      cyc();
      idle();
      i_flush = 1;
      cyc();
      idle();
      total_cnt++; if (o_exc_req !== 1'b1 || o_valid !== 1'b0 || o_epc !== 32'h700) $display("FAIL flush_in_wait got %0h/%0h/%h exp 1/0/00000700", o_exc_req, o_valid, o_epc); else pass_cnt++;
   endtask

   task automatic test_reset_in_exc();
      total_cnt++; if (o_exc_req !== 1'b1) $display("FAIL rst_pre_exc got %0h exp 1", o_exc_req); else pass_cnt++;
      i_rst = 1;
      cyc();
      i_rst = 0;
      total_cnt++; if (o_exc_req !== 1'b0 || o_epc !== 32'h0 || o_cause !== 5'd0 || o_ready !== 1'b1) $display("FAIL rst_in_exc got %0h/%h/%0d/%0h exp 0/00000000/0/1", o_exc_req, o_epc, o_cause, o_ready); else pass_cnt++;
   endtask

   task automatic test_fwd();
`ifdef EX_MEM_FWD_EN
      instr(32'h55, 5'd0, 1, 0, 0, 0, 32'h800);
      cyc();
      idle();
      total_cnt++; if (o_fwd_valid !== 1'b0) $display("FAIL fwd_r0 got %0h exp 0", o_fwd_valid); else pass_cnt++;
      instr(32'h99, 5'd9, 1, 0, 0, 0, 32'h804);
      cyc();
      idle();
      total_cnt++; if (o_fwd_valid !== 1'b1 || o_fwd_reg !== 5'd9 || o_fwd_data !== 32'h99) $display("FAIL fwd_alu got %0h/%0d/%h exp 1/9/00000099", o_fwd_valid, o_fwd_reg, o_fwd_data); else pass_cnt++;
      instr(32'h2000, 5'd9, 1, 1, 0, 0, 32'h808);
      cyc();
      idle();
      total_cnt++; if (o_fwd_valid !== 1'b0) $display("FAIL fwd_load got %0h exp 0", o_fwd_valid); else pass_cnt++;
`else
      instr(32'h99, 5'd9, 1, 0, 0, 0, 32'h804);
      cyc();
      idle();
      total_cnt++; if (o_fwd_valid !== 1'b0 || o_fwd_reg !== 5'd0 || o_fwd_data !== 32'h0) $display("FAIL fwd_tied got %0h/%0d/%h exp 0/0/00000000", o_fwd_valid, o_fwd_reg, o_fwd_data); else pass_cnt++;
`endif
      cyc();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_misaligned();
      test_stall();
      test_flush();
      test_reset_in_exc();
      test_fwd();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
